// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC pipeline: opcode encodings and the
// memory-stage controller state encoding.
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // True for the two opcodes that touch data memory.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl.sv
// Data-memory access controller. Launches one LW/SW at a time to a
// multi-cycle memory over a valid/ready handshake, stalls fetch while the
// access is outstanding, returns load data and flags timeout/misalignment.
module mem_stage_ctrl
  import wisc_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Instr_Valid,
  input  logic [3:0]        Opcode,
  input  logic [DATA_W-1:0] ALU_Out,
  input  logic [DATA_W-1:0] Store_Data,
  output logic              Mem_Req,
  output logic              Mem_WrEn,
  output logic [DATA_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic              Mem_Ready,
  input  logic [DATA_W-1:0] Mem_RData,
  output logic              Stall,
  output logic              Load_Valid,
  output logic [DATA_W-1:0] Load_Data,
  output logic              Mem_Err,
  output logic              Err_Sticky
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t       state;
  mem_state_t       next_state;
  logic [CNT_W-1:0] cnt;
  logic             misalign;
  logic             start;
  logic             ready_hit;
  logic             time_out;

  // State register; async reset returns to IDLE at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; Mem_Ready takes priority over the timeout check.
  always_comb begin
    start      = Instr_Valid && is_mem_op(Opcode);
    next_state = state;
    ready_hit  = 1'b0;
    time_out   = 1'b0;
    case (state)
      IDLE: if (start) next_state = BUSY;
      BUSY: begin
        if (Mem_Ready) begin
          next_state = DONE;
          ready_hit  = 1'b1;
        end else if (cnt == CNT_LAST) begin
          next_state = DONE;
          time_out   = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Fetch is frozen from the launch cycle through the last BUSY cycle, never in DONE.
  assign Stall = !rst && (((state == IDLE) && start) || (state == BUSY));

  // Request-side registers: captured at launch, held stable while BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Mem_Req   <= 1'b0;
      Mem_WrEn  <= 1'b0;
      Mem_Addr  <= '0;
      Mem_WData <= '0;
      misalign  <= 1'b0;
      cnt       <= '0;
    end else begin
      Mem_Req <= (next_state == BUSY);
      if (state == IDLE && start) begin
        Mem_WrEn  <= Opcode[0];
        Mem_Addr  <= {ALU_Out[DATA_W-1:1], 1'b0};
        Mem_WData <= Store_Data;
        misalign  <= ALU_Out[0];
        cnt       <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Completion-side registers: load writeback and error pulses land in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Load_Valid <= 1'b0;
      Load_Data  <= '0;
      Mem_Err    <= 1'b0;
      Err_Sticky <= 1'b0;
    end else begin
      Load_Valid <= 1'b0;
      Mem_Err    <= 1'b0;
      if (ready_hit) begin
        if (!Mem_WrEn) begin
          Load_Data  <= Mem_RData;
          Load_Valid <= 1'b1;
        end
        Mem_Err    <= misalign;
        Err_Sticky <= Err_Sticky | misalign;
      end else if (time_out) begin
        Load_Data  <= '0;
        Mem_Err    <= 1'b1;
        Err_Sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (DATA_W=16, TIMEOUT=64).
module tb_mem_stage_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        Instr_Valid;
  logic [3:0]  Opcode;
  logic [15:0] ALU_Out;
  logic [15:0] Store_Data;
  logic        Mem_Req;
  logic        Mem_WrEn;
  logic [15:0] Mem_Addr;
  logic [15:0] Mem_WData;
  logic        Mem_Ready;
  logic [15:0] Mem_RData;
  logic        Stall;
  logic        Load_Valid;
  logic [15:0] Load_Data;
  logic        Mem_Err;
  logic        Err_Sticky;

  int vectors     = 0;
  int miscompares = 0;

  mem_stage_ctrl #(.DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .Instr_Valid(Instr_Valid),
    .Opcode     (Opcode),
    .ALU_Out    (ALU_Out),
    .Store_Data (Store_Data),
    .Mem_Req    (Mem_Req),
    .Mem_WrEn   (Mem_WrEn),
    .Mem_Addr   (Mem_Addr),
    .Mem_WData  (Mem_WData),
    .Mem_Ready  (Mem_Ready),
    .Mem_RData  (Mem_RData),
    .Stall      (Stall),
    .Load_Valid (Load_Valid),
    .Load_Data  (Load_Data),
    .Mem_Err    (Mem_Err),
    .Err_Sticky (Err_Sticky)
  );

  always #5 clk = ~clk;

  // One comparison: counts the vector and reports any miscompare.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, then settle before checks.
  task automatic apply_stimulus(input logic iv, input logic [3:0] op, input logic [15:0] addr,
                                input logic [15:0] sd, input logic rdy, input logic [15:0] rd);
    @(negedge clk);
    Instr_Valid = iv;
    Opcode      = op;
    ALU_Out     = addr;
    Store_Data  = sd;
    Mem_Ready   = rdy;
    Mem_RData   = rd;
    #1;
  endtask

  task automatic idle_cycle(input logic rdy);
    apply_stimulus(1'b0, 4'h0, 16'h0000, 16'h0000, rdy, 16'h0000);
  endtask

  // Guards against a hung simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    Instr_Valid = 1'b0; Opcode = 4'h0; ALU_Out = '0; Store_Data = '0;
    Mem_Ready = 1'b0; Mem_RData = '0;

    // Reset state
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    check_output("rst_mem_req",    Mem_Req,    0);
    check_output("rst_stall",      Stall,      0);
    check_output("rst_load_valid", Load_Valid, 0);
    check_output("rst_load_data",  Load_Data,  0);
    check_output("rst_mem_err",    Mem_Err,    0);
    check_output("rst_err_sticky", Err_Sticky, 0);
    check_output("rst_mem_addr",   Mem_Addr,   0);
    rst = 1'b0;
    idle_cycle(1'b0);
    check_output("idle_stall", Stall, 0);

    // LW 0x0040, ready on third request cycle: stall 4 cycles
    apply_stimulus(1'b1, 4'b1000, 16'h0040, 16'h0000, 1'b0, 16'h0000);
    check_output("lw_launch_stall", Stall,   1);
    check_output("lw_launch_req",   Mem_Req, 0);
    for (int b = 1; b <= 3; b++) begin
      apply_stimulus(1'b0, 4'h0, 16'h0000, 16'h0000, (b == 3), 16'hBEEF);
      check_output("lw_busy_req",   Mem_Req,  1);
      check_output("lw_busy_stall", Stall,    1);
      check_output("lw_busy_addr",  Mem_Addr, 16'h0040);
      check_output("lw_busy_wren",  Mem_WrEn, 0);
    end
    idle_cycle(1'b0);
    check_output("lw_done_stall", Stall,      0);
    check_output("lw_done_req",   Mem_Req,    0);
    check_output("lw_done_lv",    Load_Valid, 1);
    check_output("lw_done_data",  Load_Data,  16'hBEEF);
    check_output("lw_done_err",   Mem_Err,    0);

    // SW 0x0010 on the cycle after DONE, ready in first BUSY cycle: stall 2 cycles
    apply_stimulus(1'b1, 4'b1001, 16'h0010, 16'h1234, 1'b0, 16'h0000);
    check_output("sw_launch_stall", Stall,      1);
    check_output("sw_gap_req",      Mem_Req,    0);
    check_output("sw_launch_lv",    Load_Valid, 0);
    apply_stimulus(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 16'h5555);
    check_output("sw_busy_req",   Mem_Req,   1);
    check_output("sw_busy_stall", Stall,     1);
    check_output("sw_busy_wren",  Mem_WrEn,  1);
    check_output("sw_busy_wdata", Mem_WData, 16'h1234);
    check_output("sw_busy_addr",  Mem_Addr,  16'h0010);
    idle_cycle(1'b0);
    check_output("sw_done_stall", Stall,      0);
    check_output("sw_done_lv",    Load_Valid, 0);
    check_output("sw_done_err",   Mem_Err,    0);
    check_output("sw_done_data",  Load_Data,  16'hBEEF);

    // LW with ready on the last allowed cycle: ready wins over timeout
    apply_stimulus(1'b1, 4'b1000, 16'h0120, 16'h0000, 1'b0, 16'h0000);
    for (int b = 1; b <= TIMEOUT; b++) begin
      apply_stimulus(1'b0, 4'h0, 16'h0000, 16'h0000, (b == TIMEOUT), 16'h7E57);
      check_output("edge_busy_req", Mem_Req, 1);
    end
    idle_cycle(1'b0);
    check_output("edge_done_lv",     Load_Valid, 1);
    check_output("edge_done_data",   Load_Data,  16'h7E57);
    check_output("edge_done_err",    Mem_Err,    0);
    check_output("edge_done_sticky", Err_Sticky, 0);

    // LW with no ready: request held TIMEOUT cycles, then error pulse
    apply_stimulus(1'b1, 4'b1000, 16'h0200, 16'h0000, 1'b0, 16'h0000);
    for (int b = 1; b <= TIMEOUT; b++) begin
      idle_cycle(1'b0);
      check_output("to_busy_req",   Mem_Req, 1);
      check_output("to_busy_stall", Stall,   1);
    end
    idle_cycle(1'b0);
    check_output("to_done_req",    Mem_Req,    0);
    check_output("to_done_stall",  Stall,      0);
    check_output("to_done_err",    Mem_Err,    1);
    check_output("to_done_lv",     Load_Valid, 0);
    check_output("to_done_data",   Load_Data,  0);
    check_output("to_done_sticky", Err_Sticky, 1);
    idle_cycle(1'b0);
    check_output("to_after_err",    Mem_Err,    0);
    check_output("to_after_sticky", Err_Sticky, 1);

    // Reset during the second BUSY cycle
    apply_stimulus(1'b1, 4'b1000, 16'h0300, 16'h0000, 1'b0, 16'h0000);
    idle_cycle(1'b0);
    check_output("rb_busy1_req", Mem_Req, 1);
    idle_cycle(1'b0);
    rst = 1'b1;
    #1;
    check_output("rb_req",    Mem_Req,    0);
    check_output("rb_stall",  Stall,      0);
    check_output("rb_sticky", Err_Sticky, 0);
    idle_cycle(1'b0);
    rst = 1'b0;
    idle_cycle(1'b0);
    check_output("rb_idle_req",   Mem_Req, 0);
    check_output("rb_idle_stall", Stall,   0);

    // ADD with Mem_Ready toggling: no activity
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 4'b0000, 16'h0040, 16'h0000, i[0], 16'hFFFF);
      check_output("add_stall", Stall,   0);
      check_output("add_req",   Mem_Req, 0);
    end

    // Misaligned LW to 0x0041: aligned request, data returned, error pulse
    apply_stimulus(1'b1, 4'b1000, 16'h0041, 16'h0000, 1'b0, 16'h0000);
    check_output("mis_launch_stall", Stall, 1);
    apply_stimulus(1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 16'hA5A5);
    check_output("mis_busy_req",  Mem_Req,  1);
    check_output("mis_busy_addr", Mem_Addr, 16'h0040);
    idle_cycle(1'b0);
    check_output("mis_done_lv",     Load_Valid, 1);
    check_output("mis_done_data",   Load_Data,  16'hA5A5);
    check_output("mis_done_err",    Mem_Err,    1);
    check_output("mis_done_sticky", Err_Sticky, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
